// File: rtl/regfile4_wr_pkg.sv
// Shared constants and state encoding for the 4-entry write-port register file.
// Imported by the top module and by the write-enable decoder.
package regfile4_wr_pkg;

    localparam int ADDR_W        = 2;
    localparam int NUM_REGS      = 4;
    localparam int DEFAULT_WIDTH = 16;
    localparam int COUNT_W       = 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : regfile4_wr_pkg

// File: rtl/regfile4_wr_dec2to4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when en is low.
module dec2to4
    import regfile4_wr_pkg::*;
(
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] dec
);

    always_comb begin
        dec = '0;
        if (en) begin
            dec[addr] = 1'b1;
        end
    end

endmodule : dec2to4

// File: rtl/regfile4_wr.sv
// 4-entry register file: one write port with valid/ready, two forwarding read ports,
// and a post-reset INIT sweep that clears every entry before writes are accepted.
module regfile4_wr
    import regfile4_wr_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit ZERO_REG_EN = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [ADDR_W-1:0]  rd_addr_a,
    output logic [WIDTH-1:0]   rd_data_a,
    input  logic [ADDR_W-1:0]  rd_addr_b,
    output logic [WIDTH-1:0]   rd_data_b,
    output logic               init_done,
    output logic [COUNT_W-1:0] wr_count,
    output state_e             dbg_state
);

    // Handshake: a write transfers on a rising edge where wr_valid && wr_ready and
    // reset is low; wr_valid may be held while wr_ready is low and is simply ignored.

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    sweep_q, sweep_d;
    logic [COUNT_W-1:0]   wr_count_q, wr_count_d;
    logic [WIDTH-1:0]     mem_q [NUM_REGS];
    logic [WIDTH-1:0]     mem_d [NUM_REGS];

    logic                 in_init;
    logic                 wr_accept;
    logic                 dec_en;
    logic [ADDR_W-1:0]    dec_addr;
    logic [WIDTH-1:0]     wr_value;
    logic [NUM_REGS-1:0]  wr_en;
    logic [NUM_REGS-1:0]  store_en;

    logic [ADDR_W-1:0]    rd_addr [2];
    logic [WIDTH-1:0]     rd_data [2];

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            sweep_q    <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign in_init   = (state_q == INIT);
    assign wr_ready  = (state_q == RUN);
    assign init_done = (state_q == RUN);
    assign dbg_state = state_q;

    // A write presented during a reset cycle must neither land nor count.
    assign wr_accept = wr_valid && wr_ready && !reset;

    assign wr_count_d = wr_count_q + COUNT_W'(wr_accept);
    assign wr_count   = wr_count_q;

    // ---------------- write path ----------------
    assign dec_en   = !reset && (in_init || wr_accept);
    assign dec_addr = in_init ? sweep_q : wr_addr;
    assign wr_value = in_init ? '0 : wr_data;

    dec2to4 u_dec (
        .en   (dec_en),
        .addr (dec_addr),
        .dec  (wr_en)
    );

    always_comb begin
        store_en = wr_en;
        if (ZERO_REG_EN) begin
            store_en[NUM_REGS-1] = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = mem_q[i];
            if (store_en[i]) begin
                mem_d[i] = wr_value;
            end
        end
    end

    // Storage carries no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ---------------- read ports ----------------
    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = mem_q[rd_addr[p]];
            if (in_init) begin
                rd_data[p] = '0;
            end else if (ZERO_REG_EN && (rd_addr[p] == ADDR_W'(NUM_REGS - 1))) begin
                rd_data[p] = '0;
            end else if (wr_accept && (rd_addr[p] == wr_addr)) begin
                rd_data[p] = wr_data;
            end
        end
    end

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];

    // ---------------- embedded checks ----------------
    a_wr_en_onehot : assert property (@(posedge clk) $onehot0(wr_en));
    a_no_write_in_reset : assert property (@(posedge clk) reset |-> (wr_en == '0));

endmodule : regfile4_wr
